// File: rtl/mems_spi_master_pkg.sv
// Shared definitions for the MEMS mirror DAC SPI path: frame width, FSM
// state encoding and the DAC command layout used by the scan ROM.
package mems_pkg;

    localparam int MEMS_DAC_WORD_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } mems_state_e;

    // DAC frame layout: [23:22] unused, [21:19] command, [18:16] channel, [15:0] data
    localparam logic [2:0] DAC_CMD_WRITE_UPDATE = 3'b011;
    localparam logic [2:0] DAC_CMD_SW_RESET     = 3'b101;
    localparam logic [2:0] DAC_CMD_REF_SETUP    = 3'b111;

    localparam logic [2:0] DAC_CH_ALL           = 3'b111;

    localparam logic [15:0] DAC_REF_EXTERNAL    = 16'h0000;
    localparam logic [15:0] DAC_REF_INTERNAL    = 16'h0001;

    // Assemble one DAC command word as stored in the scan ROM
    function automatic logic [MEMS_DAC_WORD_W-1:0] mems_dac_word(
        input logic [2:0]  cmd,
        input logic [2:0]  channel,
        input logic [15:0] value
    );
        return {2'b00, cmd, channel, value};
    endfunction

endpackage

// File: rtl/mems_spi_master_if.sv
// Bundle between the MEMS sequencer and the DAC SPI transmitter, including
// the three pin-level SPI outputs. The master modport is the transmitter side.
interface mems_spi_master_if
    import mems_pkg::*;
#(
    parameter int WORD_W = MEMS_DAC_WORD_W
);

    logic              start;
    logic [WORD_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              mosi;
    logic              sync_n;

    modport master (
        input  start,
        input  data_in,
        output busy,
        output done,
        output sclk,
        output mosi,
        output sync_n
    );

    modport slave (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  sclk,
        input  mosi,
        input  sync_n
    );

endinterface

// File: rtl/mems_spi_phase_timer.sv
// Loadable down-counter that flags the last cycle of a timed phase.
// Loading N-1 gives a phase of exactly N cycles, ending on the terminal cycle.
module mems_spi_phase_timer
    import mems_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadVal,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    // Count down from the loaded value and rest at zero until reloaded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_terminal = (r_count == '0);

endmodule

// File: rtl/mems_spi_master.sv
// SPI transmitter for the MEMS mirror DAC. Serialises one command word per
// start, MSB first, framed by SYNC_n; the DAC samples MOSI on SCLK falling edges.
module mems_spi_master
    import mems_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int WORD_W     = MEMS_DAC_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    mems_spi_master_if.master bus
);

    localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

    mems_state_e       r_state;
    logic [WORD_W-2:0] r_shiftReg;
    logic [BW-1:0]     r_bitCnt;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_syncN;
    logic              r_busy;
    logic              r_done;

    mems_state_e       w_stateNext;
    logic [WORD_W-2:0] w_shiftNext;
    logic [BW-1:0]     w_bitCntNext;
    logic              w_sclkNext;
    logic              w_mosiNext;
    logic              w_syncNNext;
    logic              w_busyNext;
    logic              w_doneNext;
    logic              w_timerLoad;
    logic [TW-1:0]     w_timerVal;
    logic              w_phaseEnd;

    // One timer serves every half-period and the inter-frame gap
    mems_spi_phase_timer #(
        .WIDTH (TW)
    ) u_phaseTimer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_timerLoad),
        .i_loadVal  (w_timerVal),
        .o_terminal (w_phaseEnd)
    );

    // State and output registers; every pin is driven straight from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_sclk     <= 1'b1;
            r_mosi     <= 1'b0;
            r_syncN    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_shiftReg <= w_shiftNext;
            r_bitCnt   <= w_bitCntNext;
            r_sclk     <= w_sclkNext;
            r_mosi     <= w_mosiNext;
            r_syncN    <= w_syncNNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
        end
    end

    // Frame sequencing: MOSI only moves on SCLK rising, so it is stable at each fall
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shiftReg;
        w_bitCntNext = r_bitCnt;
        w_sclkNext   = r_sclk;
        w_mosiNext   = r_mosi;
        w_syncNNext  = r_syncN;
        w_busyNext   = r_busy;
        w_doneNext   = 1'b0;
        w_timerLoad  = 1'b0;
        w_timerVal   = DIV_LOAD;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_shiftNext  = bus.data_in[WORD_W-2:0];
                    w_mosiNext   = bus.data_in[WORD_W-1];
                    w_syncNNext  = 1'b0;
                    w_busyNext   = 1'b1;
                    w_bitCntNext = '0;
                    w_timerLoad  = 1'b1;
                    w_stateNext  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_phaseEnd) begin
                    w_sclkNext  = 1'b0;
                    w_timerLoad = 1'b1;
                    w_stateNext = S_LOW;
                end
            end
            S_LOW: begin
                if (w_phaseEnd) begin
                    w_sclkNext  = 1'b1;
                    w_timerLoad = 1'b1;
                    if (r_bitCnt == LAST_BIT) begin
                        w_stateNext = S_HOLD;
                    end else begin
                        w_mosiNext   = r_shiftReg[WORD_W-2];
                        w_shiftNext  = r_shiftReg << 1;
                        w_bitCntNext = r_bitCnt + BW'(1);
                        w_stateNext  = S_HIGH;
                    end
                end
            end
            S_HIGH: begin
                if (w_phaseEnd) begin
                    w_sclkNext  = 1'b0;
                    w_timerLoad = 1'b1;
                    w_stateNext = S_LOW;
                end
            end
            S_HOLD: begin
                if (w_phaseEnd) begin
                    w_syncNNext = 1'b1;
                    w_timerLoad = 1'b1;
                    w_timerVal  = GAP_LOAD;
                    w_stateNext = S_GAP;
                end
            end
            S_GAP: begin
                if (w_phaseEnd) begin
                    w_busyNext  = 1'b0;
                    w_doneNext  = 1'b1;
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.sclk   = r_sclk;
    assign bus.mosi   = r_mosi;
    assign bus.sync_n = r_syncN;

endmodule

// File: tb/tb_mems_spi_master.sv
// Bench for mems_spi_master: two instances (CLK_DIV=4/GAP=2 and CLK_DIV=1/GAP=1)
// tracked every cycle against a timing model built from the frame arithmetic,
// plus a falling-edge capture of MOSI that rebuilds each transmitted word.
module tb_mems_spi_master;

    localparam int WW    = 24;
    localparam int DIV_A = 4;
    localparam int GAP_A = 2;
    localparam int DIV_B = 1;
    localparam int GAP_B = 1;

    logic clk;
    logic rst;
    logic [1:0]    iStart;
    logic [WW-1:0] iData [2];
    logic [1:0]    oBusy, oDone, oSclk, oMosi, oSync;

    int checks;
    int failures;
    int cyc;
    bit checkEn;

    // Reference model state, one slot per instance
    bit            act      [2];
    int            t0       [2];
    logic [WW-1:0] mWord    [2];
    logic          idleMosi [2];

    // Falling-edge capture state, one slot per instance
    logic          prevSclk    [2];
    logic          prevSync    [2];
    logic          prevBusy    [2];
    logic [WW-1:0] capWord     [2];
    int            fallCnt     [2];
    logic [WW-1:0] lastWord    [2];
    int            lastFalls   [2];
    int            busyRun     [2];
    int            lastBusy    [2];
    int            syncHighRun [2];
    int            lastSyncHigh[2];

    mems_spi_master_if #(.WORD_W(WW)) ifA ();
    mems_spi_master_if #(.WORD_W(WW)) ifB ();

    mems_spi_master #(.CLK_DIV(DIV_A), .GAP_CYCLES(GAP_A), .WORD_W(WW)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    mems_spi_master #(.CLK_DIV(DIV_B), .GAP_CYCLES(GAP_B), .WORD_W(WW)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    assign ifA.start   = iStart[0];
    assign ifB.start   = iStart[1];
    assign ifA.data_in = iData[0];
    assign ifB.data_in = iData[1];
    assign oBusy = {ifB.busy,   ifA.busy};
    assign oDone = {ifB.done,   ifA.done};
    assign oSclk = {ifB.sclk,   ifA.sclk};
    assign oMosi = {ifB.mosi,   ifA.mosi};
    assign oSync = {ifB.sync_n, ifA.sync_n};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Overall time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int s, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s dut=%0d cyc=%0d got=%0h want=%0h", name, s, cyc, actual, expected);
        end
    endtask

    function automatic int frameLen(input int s);
        int div, gap;
        div = (s == 0) ? DIV_A : DIV_B;
        gap = (s == 0) ? GAP_A : GAP_B;
        return (2 * WW + 1) * div + gap + 1;
    endfunction

    // Expected {busy, done, sclk, sync_n, mosi} for the current cycle, from frame offsets
    function automatic logic [4:0] expectOut(input int s);
        int div, off, len, p, n, idx;
        logic b, d, sc, sy, m;
        div = (s == 0) ? DIV_A : DIV_B;
        len = frameLen(s);
        off = cyc - t0[s];
        b  = 1'b0;
        d  = 1'b0;
        sc = 1'b1;
        sy = 1'b1;
        m  = idleMosi[s];
        if (act[s] && off >= 1 && off < len) begin
            b  = 1'b1;
            sy = (off > (2 * WW + 1) * div);
            p  = off - 1 - div;
            if (p >= 0 && p < 2 * WW * div && ((p / div) % 2) == 0) sc = 1'b0;
            if (off < 1 + 2 * div) begin
                idx = WW - 1;
            end else begin
                n = (off - 1 - 2 * div) / (2 * div) + 1;
                if (n > WW - 1) n = WW - 1;
                idx = WW - 1 - n;
            end
            m = mWord[s][idx];
        end
        if (act[s] && off == len) d = 1'b1;
        return {b, d, sc, sy, m};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    for (genvar g = 0; g < 2; g++) begin : gTrack
        // Model: accept a start only when no frame is in flight; reset aborts
        always @(posedge clk) begin
            if (rst) begin
                act[g]      <= 1'b0;
                idleMosi[g] <= 1'b0;
            end else if (iStart[g] && (!act[g] || (cyc - t0[g]) >= frameLen(g))) begin
                act[g]      <= 1'b1;
                t0[g]       <= cyc;
                mWord[g]    <= iData[g];
                idleMosi[g] <= iData[g][0];
            end
        end

        // Per-cycle comparison and falling-edge word capture
        always @(negedge clk) begin
            if (checkEn) begin
                checkOutput("busy",   g, 64'(oBusy[g]), 64'(expectOut(g) >> 4));
                checkOutput("done",   g, 64'(oDone[g]), 64'(expectOut(g) >> 3) & 64'd1);
                checkOutput("sclk",   g, 64'(oSclk[g]), 64'(expectOut(g) >> 2) & 64'd1);
                checkOutput("sync_n", g, 64'(oSync[g]), 64'(expectOut(g) >> 1) & 64'd1);
                checkOutput("mosi",   g, 64'(oMosi[g]), 64'(expectOut(g)) & 64'd1);

                if (prevSync[g] && !oSync[g]) begin
                    capWord[g] <= '0;
                    fallCnt[g] <= 0;
                    lastSyncHigh[g] <= syncHighRun[g];
                    syncHighRun[g]  <= 0;
                end else if (oSync[g]) begin
                    syncHighRun[g] <= syncHighRun[g] + 1;
                end
                if (prevSclk[g] && !oSclk[g]) begin
                    capWord[g] <= {capWord[g][WW-2:0], oMosi[g]};
                    fallCnt[g] <= fallCnt[g] + 1;
                end
                if (!prevSync[g] && oSync[g]) begin
                    lastWord[g]  <= capWord[g];
                    lastFalls[g] <= fallCnt[g];
                end
                if (oBusy[g]) begin
                    busyRun[g] <= busyRun[g] + 1;
                end else if (prevBusy[g]) begin
                    lastBusy[g] <= busyRun[g];
                    busyRun[g]  <= 0;
                end
                prevSclk[g] <= oSclk[g];
                prevSync[g] <= oSync[g];
                prevBusy[g] <= oBusy[g];
            end
        end
    end

    // One-cycle start pulse; data_in is scrambled afterwards since it is don't-care
    task automatic applyStimulus(input int s, input logic [WW-1:0] w);
        @(negedge clk);
        iData[s]  = w;
        iStart[s] = 1'b1;
        @(negedge clk);
        iStart[s] = 1'b0;
        iData[s]  = WW'($urandom);
    endtask

    // Wait for the done pulse; optionally throw ignored starts at the DUT while busy
    task automatic waitDone(input int s, input bit spurious);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 500) begin
            @(negedge clk);
            n++;
            if (oDone[s]) begin
                seen = 1'b1;
            end else if (spurious) begin
                iStart[s] = oBusy[s] && ($urandom_range(0, 15) == 0);
                iData[s]  = WW'($urandom);
            end
        end
        iStart[s] = 1'b0;
        checkOutput("doneSeen", s, 64'(seen), 64'd1);
    endtask

    typedef struct {
        int            sel;
        int            idleCycles;
        logic [WW-1:0] data;
        logic [WW-1:0] expWord;
        int            expFalls;
        int            expBusy;
    } frame_vec_t;

    frame_vec_t vecs [6];

    initial begin
        int falls;
        int n;
        int doneHits;
        int s;
        logic prev;
        logic [WW-1:0] w;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        checkEn  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0;        t0[k] = 0;          mWord[k] = '0;
            idleMosi[k] = 1'b0;   prevSclk[k] = 1'b1; prevSync[k] = 1'b1;
            prevBusy[k] = 1'b0;   capWord[k] = '0;    fallCnt[k] = 0;
            lastWord[k] = '0;     lastFalls[k] = 0;   busyRun[k] = 0;
            lastBusy[k] = 0;      syncHighRun[k] = 0; lastSyncHigh[k] = 0;
            iData[k] = '0;
        end
        iStart = 2'b00;

        vecs[0] = '{0, 0, 24'hA53C0F, 24'hA53C0F, 24, 198};
        vecs[1] = '{0, 3, 24'h000000, 24'h000000, 24, 198};
        vecs[2] = '{0, 1, 24'hFFFFFF, 24'hFFFFFF, 24, 198};
        vecs[3] = '{0, 0, 24'h800001, 24'h800001, 24, 198};
        vecs[4] = '{1, 2, 24'hA53C0F, 24'hA53C0F, 24, 50};
        vecs[5] = '{1, 0, 24'h7E5A13, 24'h7E5A13, 24, 50};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state, then a long quiet stretch (checked every cycle by the model)
        for (int k = 0; k < 2; k++) begin
            checkOutput("rstBusy", k, 64'(oBusy[k]), 64'd0);
            checkOutput("rstSclk", k, 64'(oSclk[k]), 64'd1);
            checkOutput("rstSync", k, 64'(oSync[k]), 64'd1);
            checkOutput("rstMosi", k, 64'(oMosi[k]), 64'd0);
            checkOutput("rstDone", k, 64'(oDone[k]), 64'd0);
        end
        repeat (50) @(negedge clk);

        $display("[TB] table-driven frames");
        for (int i = 0; i < 6; i++) begin
            repeat (vecs[i].idleCycles) @(negedge clk);
            applyStimulus(vecs[i].sel, vecs[i].data);
            waitDone(vecs[i].sel, 1'b0);
            repeat (3) @(negedge clk);
            checkOutput("word",    vecs[i].sel, 64'(lastWord[vecs[i].sel]),  64'(vecs[i].expWord));
            checkOutput("falls",   vecs[i].sel, 64'(lastFalls[vecs[i].sel]), 64'(vecs[i].expFalls));
            checkOutput("busyLen", vecs[i].sel, 64'(lastBusy[vecs[i].sel]),  64'(vecs[i].expBusy));
        end

        $display("[TB] starts during a frame are ignored");
        applyStimulus(0, 24'hC0FFEE);
        repeat (8) @(negedge clk);
        applyStimulus(0, 24'h111111);
        repeat (88) @(negedge clk);
        applyStimulus(0, 24'h222222);
        waitDone(0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("ignWord",  0, 64'(lastWord[0]),  64'h00C0FFEE);
        checkOutput("ignFalls", 0, 64'(lastFalls[0]), 64'd24);
        checkOutput("ignBusy",  0, 64'(lastBusy[0]),  64'd198);

        $display("[TB] back-to-back frames");
        applyStimulus(0, 24'h000001);
        waitDone(0, 1'b0);
        iData[0]  = 24'hFFFFFF;
        iStart[0] = 1'b1;
        checkOutput("b2bWord1", 0, 64'(lastWord[0]), 64'h000001);
        @(negedge clk);
        iStart[0] = 1'b0;
        waitDone(0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("b2bWord2",    0, 64'(lastWord[0]),     64'hFFFFFF);
        checkOutput("b2bSyncHigh", 0, 64'(lastSyncHigh[0]), 64'd3);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(0, 24'hABCDEF);
        falls = 0;
        prev  = 1'b1;
        n     = 0;
        while (falls < 12 && n < 400) begin
            @(negedge clk);
            n++;
            if (prev && !oSclk[0]) falls++;
            prev = oSclk[0];
        end
        checkOutput("fallsBeforeRst", 0, 64'(falls), 64'd12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortSync", 0, 64'(oSync[0]), 64'd1);
        checkOutput("abortSclk", 0, 64'(oSclk[0]), 64'd1);
        checkOutput("abortBusy", 0, 64'(oBusy[0]), 64'd0);
        checkOutput("abortMosi", 0, 64'(oMosi[0]), 64'd0);
        doneHits = 0;
        repeat (20) begin
            @(negedge clk);
            if (oDone[0]) doneHits++;
        end
        checkOutput("abortNoDone", 0, 64'(doneHits),     64'd0);
        checkOutput("abortFalls",  0, 64'(lastFalls[0]), 64'd12);
        applyStimulus(0, 24'h123456);
        waitDone(0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("postRstWord",  0, 64'(lastWord[0]),  64'h123456);
        checkOutput("postRstFalls", 0, 64'(lastFalls[0]), 64'd24);

        $display("[TB] randomized frames with stray starts");
        for (int i = 0; i < 12; i++) begin
            s = (i < 4) ? 0 : 1;
            w = WW'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            applyStimulus(s, w);
            waitDone(s, 1'b1);
            repeat (3) @(negedge clk);
            checkOutput("rndWord",  s, 64'(lastWord[s]),  64'(w));
            checkOutput("rndFalls", s, 64'(lastFalls[s]), 64'd24);
            checkOutput("rndBusy",  s, 64'(lastBusy[s]),  (s == 0) ? 64'd198 : 64'd50);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
